ram_port_arbiter: RTL

Two-master to one-slave arbiter that sits directly upstream of the single-port synchronous RAM.
It merges the CV32E40P instruction-fetch and data OBI ports onto the RAM's req/we/addr/wdata/be interface. It routes the RAM's rdata/rvalid back to the master that issued each request.
It also decodes the RAM address window, rebases addresses to RAM-relative offsets, and returns error responses for out-of-window accesses without touching the RAM.

---
 rtl/ram_bus_pkg.sv | 19 +
 rtl/rsp_tag_pipe.sv | 32 +++
 rtl/ram_port_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ram_bus_pkg.sv
// Shared types for the RAM-side bus merge.
// Master ids, response tags and fixed constants.
package ram_bus_pkg;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } master_id_e;

  typedef struct packed {
    logic       valid;
    master_id_e id;
    logic       err;
  } rsp_tag_t;

  localparam logic [3:0]  BE_FULL   = 4'hF;
  localparam logic [31:0] RDATA_ERR = 32'h0;

endpackage

// File: rtl/rsp_tag_pipe.sv
// Fixed-latency tag shift register.
// The head stage is the response due this cycle.
module rsp_tag_pipe
  import ram_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  rsp_tag_t in_tag,
  output rsp_tag_t head
);

  rsp_tag_t stage_q [DEPTH];

  // advance every stage each cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= in_tag;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign head = stage_q[DEPTH-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Merges fetch and data ports onto one RAM port.
// Decodes the RAM window and fakes error responses.
module ram_port_arbiter
  import ram_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned SIZE_BYTES  = 4096,
  parameter int unsigned RSP_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  output logic [3:0]  ram_be_o,
  input  logic [31:0] ram_rdata_i,
  input  logic        ram_rvalid_i
);

  localparam logic [31:0] SIZE_W = 32'(SIZE_BYTES);

  master_id_e  last_grant;
  master_id_e  gnt_id;
  logic        ireq, dreq;
  logic        gnt_i, gnt_d, grant_any;
  logic [31:0] addr_sel, offset;
  logic        in_window;
  rsp_tag_t    in_tag, head;
  logic        rsp_v, rsp_err;
  logic [31:0] rsp_data;

  assign ireq = instr_req_i & ~rst;
  assign dreq = data_req_i & ~rst;

  // round-robin on conflict, lone requester always wins
  always_comb begin
    gnt_i = ireq & (~dreq | (last_grant == DATA));
    gnt_d = dreq & (~ireq | (last_grant == INSTR));
  end

  assign grant_any = gnt_i | gnt_d;
  assign gnt_id    = gnt_d ? DATA : INSTR;
  assign addr_sel  = gnt_d ? data_addr_i : instr_addr_i;
  assign offset    = addr_sel - BASE_ADDR;
  assign in_window = offset < SIZE_W;

  assign instr_gnt_o = gnt_i;
  assign data_gnt_o  = gnt_d;
  assign ram_req_o   = grant_any & in_window;
  assign ram_addr_o  = offset;
  assign ram_we_o    = gnt_d & data_we_i;
  assign ram_be_o    = gnt_d ? data_be_i : BE_FULL;
  assign ram_wdata_o = gnt_d ? data_wdata_i : '0;

  // remember the winner of each conflict
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= DATA;
    end else if (ireq && dreq) begin
      last_grant <= gnt_id;
    end
  end

  assign in_tag = '{
    valid: grant_any,
    id:    gnt_id,
    err:   ~in_window
  };

  rsp_tag_pipe #(
    .DEPTH (RSP_LATENCY)
  ) u_rsp_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .in_tag (in_tag),
    .head   (head)
  );

  // build the response due this cycle from the head tag
  always_comb begin
    rsp_v    = 1'b0;
    rsp_err  = 1'b0;
    rsp_data = RDATA_ERR;
    if (head.valid) begin
      if (head.err) begin
        rsp_v   = 1'b1;
        rsp_err = 1'b1;
      end else if (ram_rvalid_i) begin
        rsp_v    = 1'b1;
        rsp_data = ram_rdata_i;
      end
    end
  end

  // steer the response to the master that issued it
  always_comb begin
    instr_rvalid_o = rsp_v & (head.id == INSTR);
    data_rvalid_o  = rsp_v & (head.id == DATA);
    instr_err_o    = instr_rvalid_o & rsp_err;
    data_err_o     = data_rvalid_o & rsp_err;
    instr_rdata_o  = instr_rvalid_o ? rsp_data : RDATA_ERR;
    data_rdata_o   = data_rvalid_o ? rsp_data : RDATA_ERR;
  end

  rsp_rvalid_a: assert property (
    @(posedge clk) disable iff (rst)
    (head.valid && !head.err) |-> ram_rvalid_i
  );

endmodule
